ram_mailbox_mavg: RTL and testbench
===================================

// Module: ram_mailbox_mavg
// PURPOSE
//  FPGA-side consumer of the 4-word dual-port on-chip RAM "ramteste" (port s2); the HPS owns port s1.
//  Implements a polled HPS<->fabric mailbox: the HPS posts a signed 16-bit sample plus START, and
//  this block runs it through a TAPS-point moving average. It then writes RESULT and STATUS back
//  and clears START. Sits directly on the soc_system ramteste_s2_* conduit.
//  Mailbox map (word addr): 0 CTRL [0]=START [1]=CLEAR_HIST; 1 DATA_IN [15:0] signed;
//                           2 RESULT [31:0] sign-extended; 3 STATUS [0]=DONE [31:16]=sample count.
// PARAMETERS
//  TAPS      4   moving-average length; power of 2, range 2..64
//  RD_LAT    1   RAM s2 read latency in cycles, range 1..2
//  POLL_GAP  16  idle cycles between CTRL polls, range >=1
// PORTS
//  clk_clk           in   1   system clock, shared with ramteste clk2
//  reset_reset_n     in   1   asynchronous active-low reset
//  enable            in   1   1 = polling allowed; sampled only in IDLE
//  ram_address       out  2   -> ramteste_s2_address
//  ram_chipselect    out  1   -> ramteste_s2_chipselect
//  ram_clken         out  1   -> ramteste_s2_clken
//  ram_write         out  1   -> ramteste_s2_write
//  ram_writedata     out  32  -> ramteste_s2_writedata
//  ram_byteenable    out  4   -> ramteste_s2_byteenable
//  ram_readdata      in   32  <- ramteste_s2_readdata
//  busy              out  1   1 in any state other than IDLE/GAP
//  done_pulse        out  1   1-cycle pulse when CTRL clear is written
// BEHAVIOUR
//  Reset: every output 0; sample history, sum, count=0; FSM=IDLE. Async assert, sync release.
//  ram_clken = ram_chipselect. ram_byteenable = 4'hF whenever ram_chipselect=1, else 0.
//  Every RAM access is 1 cycle with chipselect=1. Read data is captured exactly RD_LAT cycles later.
//  FSM:
//   IDLE   -> RD_CTRL when enable=1
//   RD_CTRL  issue read addr0 -> WAIT_C (RD_LAT cycles)
//   WAIT_C   capture; START=0 -> GAP; START=1 -> RD_DATA
//   RD_DATA  issue read addr1 -> WAIT_D (RD_LAT cycles)
//   WAIT_D   capture sample; latch CLEAR_HIST -> CALC
//   CALC     1 cycle:
//            if CLEAR_HIST: history=0, sum=0 before the update
//            sum += x_new - x_oldest; shift in x_new
//            y = sum >>> log2(TAPS) (arithmetic, floor)
//            count += 1, wraps mod 2^16
//   WR_RES   write addr2 = sign-extend(y)
//   WR_STAT  write addr3 = {count,15'b0,1'b1}
//   WR_CTRL  write addr0 = 0; done_pulse=1
//   GAP      wait POLL_GAP cycles -> IDLE
//  Latency, START seen -> CTRL cleared: 2*RD_LAT+6 cycles.
//  Sum width = 16+log2(TAPS) signed: no overflow possible.
//  Protocol rule (HPS side): write DATA_IN before CTRL and never write CTRL while START=1.
//   No arbitration is done against s1; simultaneous same-word writes are undefined.
//  enable dropping mid-transaction: the transaction completes; it only stops the next poll.
//  Reset mid-operation: chipselect/write drop to 0 asynchronously; a partially written mailbox
//   remains, and the HPS must rewrite START.
//  CLEAR_HIST with START=0 is ignored.
// STRUCTURE
//  Package ram_mailbox_pkg:
//   word addresses ADDR_CTRL/DATA/RESULT/STATUS
//   CTRL/STATUS bit positions
//   FSM state enum
//  Sub-module mavg_core (TAPS): history shift register + running sum + shift.
//   Ports: clk, rst_n, clr, valid_in, x_in[15:0], y_out.
//  The top holds the FSM, RAM sequencing and the counter.
// TESTING
//  Bench models ramteste s2 with RD_LAT-cycle reads; HPS side is a backdoor write task; TAPS=4.
//  1 Reset:
//    hold reset_reset_n=0 -> all outputs 0.
//    Release with enable=1 -> first access is a read of addr0, 1 cycle after IDLE.
//  2 Single sample:
//    DATA=400, CTRL=1 -> RESULT=100, STATUS=0x0001_0001, CTRL=0.
//    One done_pulse; START-to-clear latency = 8 cycles.
//  3 Sequence 100,200,300,400,500 -> RESULT 25,75,150,250,350; STATUS count=5.
//  4 Signed/floor, after clear: -8 -> -2 (0xFFFF_FFFE); then -1 -> -3 (sum -9>>>2).
//    Extremes: four x 32767 -> 32767; four x -32768 -> -32768.
//  5 CLEAR_HIST: after test 3, DATA=40, CTRL=3 -> RESULT=10.
//    Repeat with CTRL=2 only -> no access beyond CTRL polls.
//  6 Reset/enable:
//    reset_reset_n=0 during WR_RES -> chipselect=0 same cycle, count=0.
//    After release, START still set -> reprocessed, count=1.
//    enable=0 -> no RAM access for 1000 cycles.

Source files
------------

// File: rtl/ram_mailbox_pkg.sv
// ram_mailbox_pkg
//   Shared definitions for the HPS<->fabric mailbox held in the 4-word
//   "ramteste" dual-port RAM: word addresses, CTRL/STATUS bit positions
//   and the sequencer state encoding.
//   No ports (package).

package ram_mailbox_pkg;

    // Mailbox word addresses
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL word bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    // STATUS word layout
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CTRL,
        S_WAIT_C,
        S_RD_DATA,
        S_WAIT_D,
        S_CALC,
        S_WR_RES,
        S_WR_STAT,
        S_WR_CTRL,
        S_GAP
    } state_t;

endpackage

// File: rtl/mavg_core.sv
// mavg_core
//   TAPS-point moving average of signed 16-bit samples: a history shift
//   register plus a running sum, divided by TAPS with an arithmetic shift
//   (floor rounding).
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset (clears history and sum)
//     clr      in   with valid_in: discard history before absorbing x_in
//     valid_in in   absorb x_in this cycle
//     x_in     in   16-bit signed sample
//     y_out    out  16-bit signed average of the last TAPS samples

module mavg_core #(
    parameter int TAPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        valid_in,
    input  logic [15:0] x_in,
    output logic [15:0] y_out
);

    localparam int SH    = $clog2(TAPS);
    localparam int SUM_W = 16 + SH;

    logic signed [15:0]      hist_p0 [TAPS];
    logic signed [SUM_W-1:0] sum_p0;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [SUM_W-1:0] sum_base;
    logic signed [SUM_W-1:0] x_ext;
    logic signed [SUM_W-1:0] old_ext;

    // A clear zeroes history and sum before the new sample goes in, so
    // the oldest tap and the base sum are forced to zero here.
    always_comb begin
        x_ext    = {{SH{x_in[15]}}, x_in};
        old_ext  = clr ? '0 : {{SH{hist_p0[TAPS-1][15]}}, hist_p0[TAPS-1]};
        sum_base = clr ? '0 : sum_p0;
        sum_nxt  = sum_base + x_ext - old_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) hist_p0[i] <= '0;
            sum_p0 <= '0;
        end else if (valid_in) begin
            hist_p0[0] <= x_in;
            for (int i = 1; i < TAPS; i++) hist_p0[i] <= clr ? '0 : hist_p0[i-1];
            sum_p0 <= sum_nxt;
        end
    end

    // Dropping the low SH bits of the sum is the floor arithmetic shift;
    // the remaining 16 bits always hold the average without overflow.
    assign y_out = sum_p0[SUM_W-1:SH];

endmodule

// File: rtl/ram_mailbox_mavg.sv
// ram_mailbox_mavg
//   Fabric side of a polled mailbox in the "ramteste" RAM (port s2). Polls
//   CTRL; on START reads DATA_IN, runs it through a TAPS-point moving
//   average, writes RESULT and STATUS, then clears CTRL.
//   Ports:
//     clk_clk         in   system clock
//     reset_reset_n   in   asynchronous active-low reset
//     enable          in   polling allowed (sampled in IDLE)
//     ram_address     out  s2 word address
//     ram_chipselect  out  s2 access strobe (one cycle per access)
//     ram_clken       out  s2 clock enable, equals chipselect
//     ram_write       out  s2 write strobe
//     ram_writedata   out  s2 write data
//     ram_byteenable  out  4'hF during any access
//     ram_readdata    in   s2 read data, valid RD_LAT cycles after a read
//     busy            out  sequencer is in a transaction
//     done_pulse      out  one cycle while CTRL is being cleared

module ram_mailbox_mavg
    import ram_mailbox_pkg::*;
#(
    parameter int TAPS     = 4,
    parameter int RD_LAT   = 1,
    parameter int POLL_GAP = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    output logic [1:0]  ram_address,
    output logic        ram_chipselect,
    output logic        ram_clken,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    output logic [3:0]  ram_byteenable,
    input  logic [31:0] ram_readdata,
    output logic        busy,
    output logic        done_pulse
);

    localparam int TMR_W = $clog2(POLL_GAP + RD_LAT + 1);

    // Reset asserts immediately, releases two clocks later in step with clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync <= 2'b00;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q;
    logic               clr_p0;
    logic [15:0]        sample_p0;
    logic [15:0]        cnt_q;
    logic [15:0]        y_p1;
    logic               wait_last;
    logic               gap_last;
    logic               cs, wr;
    logic [1:0]         addr;
    logic [31:0]        wdata;
    logic               unused_rd;

    assign unused_rd = ^ram_readdata[31:16];
    assign wait_last = (tmr_q == TMR_W'(RD_LAT - 1));
    assign gap_last  = (tmr_q == TMR_W'(POLL_GAP - 1));

    // Sequencer state, wait timer, captured mailbox words and counter
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            clr_p0    <= 1'b0;
            sample_p0 <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
            if (state_q == S_WAIT_C && wait_last)
                clr_p0 <= ram_readdata[CTRL_CLEAR_BIT];
            if (state_q == S_WAIT_D && wait_last)
                sample_p0 <= ram_readdata[15:0];
            if (state_q == S_CALC)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // Average stage: updated at the end of CALC, read back in WR_RES
    mavg_core #(.TAPS(TAPS)) u_mavg (
        .clk      (clk_clk),
        .rst_n    (rst_n),
        .clr      (clr_p0),
        .valid_in (state_q == S_CALC),
        .x_in     (sample_p0),
        .y_out    (y_p1)
    );

    always_comb begin
        state_d = state_q;
        cs      = 1'b0;
        wr      = 1'b0;
        addr    = ADDR_CTRL;
        wdata   = '0;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_RD_CTRL;
            S_RD_CTRL: begin
                cs      = 1'b1;
                addr    = ADDR_CTRL;
                state_d = S_WAIT_C;
            end
            S_WAIT_C:  if (wait_last)
                state_d = ram_readdata[CTRL_START_BIT] ? S_RD_DATA : S_GAP;
            S_RD_DATA: begin
                cs      = 1'b1;
                addr    = ADDR_DATA;
                state_d = S_WAIT_D;
            end
            S_WAIT_D:  if (wait_last) state_d = S_CALC;
            S_CALC:    state_d = S_WR_RES;
            S_WR_RES: begin
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = ADDR_RESULT;
                wdata   = {{16{y_p1[15]}}, y_p1};
                state_d = S_WR_STAT;
            end
            S_WR_STAT: begin
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = ADDR_STATUS;
                wdata   = '0;
                wdata[STAT_COUNT_LSB +: 16] = cnt_q;
                wdata[STAT_DONE_BIT]        = 1'b1;
                state_d = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                cs      = 1'b1;
                wr      = 1'b1;
                addr    = ADDR_CTRL;
                state_d = S_GAP;
            end
            S_GAP:     if (gap_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them at once.
    assign ram_chipselect = cs;
    assign ram_clken      = cs;
    assign ram_write      = wr;
    assign ram_address    = addr;
    assign ram_writedata  = wdata;
    assign ram_byteenable = cs ? 4'hF : 4'h0;
    assign busy           = (state_q != S_IDLE) && (state_q != S_GAP);
    assign done_pulse     = (state_q == S_WR_CTRL);

endmodule

// File: tb/tb_ram_mailbox_mavg.sv
module tb_ram_mailbox_mavg;

    localparam int TAPS     = 4;
    localparam int RD_LAT   = 1;
    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_clken;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;
    logic        busy;
    logic        done_pulse;

    always #5 clk = ~clk;

    ram_mailbox_mavg #(.TAPS(TAPS), .RD_LAT(RD_LAT), .POLL_GAP(POLL_GAP)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .enable         (enable),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_readdata   (ram_readdata),
        .busy           (busy),
        .done_pulse     (done_pulse)
    );

    // ramteste model: s1 (HPS) write request plus s2 read/write
    logic [31:0] mem [4] = '{default: 32'h0};
    logic [31:0] rd_s1 = 32'h0;
    logic [31:0] rd_s2 = 32'h0;
    logic        hps_we = 1'b0;
    logic [1:0]  hps_addr = 2'd0;
    logic [31:0] hps_data = 32'h0;

    always @(posedge clk) begin
        if (hps_we) mem[hps_addr] <= hps_data;
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                rd_s1 <= mem[ram_address];
            end
        end
        rd_s2 <= rd_s1;
    end
    assign ram_readdata = (RD_LAT == 2) ? rd_s2 : rd_s1;

    // Access monitor
    int cyc = 0;
    int n_acc = 0;
    int n_other = 0;
    int n_done = 0;
    int last_rd0 = 0;
    int wr0 = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ram_chipselect) begin
            n_acc++;
            if (ram_write || ram_address != 2'd0) n_other++;
            if (!ram_write && ram_address == 2'd0) last_rd0 = cyc;
            if (ram_write && ram_address == 2'd0) wr0 = cyc;
        end
        if (done_pulse) n_done++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic hps_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        hps_addr = a;
        hps_data = d;
        hps_we   = 1'b1;
        @(negedge clk);
        hps_we   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_pulse && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'b0, done_pulse}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [15:0] x, input logic [1:0] ctrl);
        hps_wr(2'd1, {16'h0, x});
        hps_wr(2'd0, {30'h0, ctrl});
        wait_done(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int d0;
        int a0;
        logic [15:0] seq_x [5];
        logic [31:0] seq_y [5];
        seq_x = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
        seq_y = '{32'd25, 32'd75, 32'd150, 32'd250, 32'd350};

        // 1 Reset
        repeat (3) @(negedge clk);
        chk("rst_ctl", {25'b0, ram_chipselect, ram_clken, ram_write, ram_address, busy, done_pulse}, 32'h0);
        chk("rst_wdata", ram_writedata, 32'h0);
        chk("rst_be", {28'b0, ram_byteenable}, 32'h0);
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ram_chipselect && k < 20);
        chk("first_lat", k, 3);
        chk("first_acc", {29'b0, ram_write, ram_address}, 32'h0);
        chk("first_be", {27'b0, ram_clken, ram_byteenable}, 32'h1F);

        // 2 Single sample
        d0 = n_done;
        run("single", 16'd400, 2'd1);
        chk("single_res", mem[2], 32'd100);
        chk("single_stat", mem[3], 32'h0001_0001);
        chk("single_ctrl", mem[0], 32'h0);
        chk("single_lat", wr0 - last_rd0 + 1, 8);
        repeat (40) @(negedge clk);
        chk("single_pulses", n_done - d0, 1);

        // 3 Sequence from fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run("seq", seq_x[i], 2'd1);
            chk($sformatf("seq_res%0d", i), mem[2], seq_y[i]);
        end
        chk("seq_stat", mem[3], 32'h0005_0001);

        // 5 CLEAR_HIST
        run("clr", 16'd40, 2'd3);
        chk("clr_res", mem[2], 32'd10);
        chk("clr_stat", mem[3], 32'h0006_0001);
        a0 = n_other;
        hps_wr(2'd0, 32'd2);
        repeat (200) @(negedge clk);
        chk("clronly_acc", n_other - a0, 0);
        chk("clronly_ctrl", mem[0], 32'd2);
        chk("clronly_res", mem[2], 32'd10);

        // 4 Signed / floor / extremes
        run("neg8", 16'hFFF8, 2'd3);
        chk("neg8_res", mem[2], 32'hFFFF_FFFE);
        run("neg1", 16'hFFFF, 2'd1);
        chk("neg1_res", mem[2], 32'hFFFF_FFFD);
        run("max", 16'h7FFF, 2'd3);
        for (int i = 0; i < 3; i++) run("max", 16'h7FFF, 2'd1);
        chk("max_res", mem[2], 32'h0000_7FFF);
        run("min", 16'h8000, 2'd3);
        for (int i = 0; i < 3; i++) run("min", 16'h8000, 2'd1);
        chk("min_res", mem[2], 32'hFFFF_8000);

        // 6 Reset during WR_RES
        hps_wr(2'd1, 32'd800);
        hps_wr(2'd0, 32'd1);
        k = 0;
        while (!(ram_chipselect && ram_write && ram_address == 2'd2) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wrres_seen", {31'b0, ram_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_cs", {30'b0, ram_chipselect, ram_write}, 32'h0);
        chk("async_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        chk("start_kept", mem[0], 32'd1);
        rst_n = 1'b1;
        wait_done("rerun");
        chk("rerun_res", mem[2], 32'd200);
        chk("rerun_stat", mem[3], 32'h0001_0001);
        chk("rerun_ctrl", mem[0], 32'h0);

        // enable=0 stops polling
        enable = 1'b0;
        repeat (40) @(negedge clk);
        a0 = n_acc;
        hps_wr(2'd1, 32'd4);
        hps_wr(2'd0, 32'd1);
        repeat (1000) @(negedge clk);
        chk("disabled_acc", n_acc - a0, 0);
        chk("disabled_ctrl", mem[0], 32'd1);
        enable = 1'b1;
        wait_done("reenable");
        chk("reenable_res", mem[2], 32'd201);
        chk("reenable_stat", mem[3], 32'h0002_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
